// File: rtl/seq_div.sv
// Multi-cycle radix-2 non-restoring integer divider (DIVU/DIV) for the HI/LO path.
// Quotient lands on lo and remainder on hi; both hold until the next accepted op completes.
module seq_div #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int unsigned N     = WIDTH / STEPS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH:0]     rem_q,   rem_d;
    logic [WIDTH-1:0]   quo_q,   quo_d;
    logic [WIDTH-1:0]   dvs_q,   dvs_d;
    logic               negq_q,  negq_d;
    logic               negr_q,  negr_d;
    logic               zero_q,  zero_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               dz_q,    dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     r_step, r_shift;
    logic [WIDTH-1:0]   q_step;
    logic [WIDTH-1:0]   rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        a_neg = op[0] & dividend[WIDTH-1];
        b_neg = op[0] & divisor[WIDTH-1];
        a_mag = a_neg ? (WIDTH'(0) - dividend) : dividend;
        b_mag = b_neg ? (WIDTH'(0) - divisor)  : divisor;

        // STEPS non-restoring iterations; wrap in WIDTH+1 bits is harmless since each result fits
        r_step  = rem_q;
        q_step  = quo_q;
        r_shift = '0;
        for (int unsigned i = 0; i < STEPS; i++) begin
            r_shift   = {r_step[WIDTH-1:0], q_step[WIDTH-1]};
            q_step    = {q_step[WIDTH-2:0], 1'b0};
            r_step    = r_step[WIDTH] ? (r_shift + {1'b0, dvs_q}) : (r_shift - {1'b0, dvs_q});
            q_step[0] = ~r_step[WIDTH];
        end

        rem_fix = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (start && op[1]) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    zero_d  = (divisor == '0);
                    cnt_d   = CNT_W'(N - 1);
                    busy_d  = 1'b1;
                    state_d = (divisor == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                rem_d = r_step;
                quo_d = q_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Zero divisor: quo_q still holds |dividend|, so re-applying the sign gives it back as given
                if (zero_q) begin
                    lo_d = '1;
                    hi_d = negr_q ? (WIDTH'(0) - quo_q) : quo_q;
                end else begin
                    lo_d = negq_q ? (WIDTH'(0) - quo_q) : quo_q;
                    hi_d = negr_q ? (WIDTH'(0) - rem_fix) : rem_fix;
                end
                dz_d    = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed vector table, busy/reset corner sequences, and randomised
// back-to-back ops against a behavioural model on STEPS = 1, 2 and 4 instances.
module tb_seq_div;

    localparam int unsigned W  = 32;
    localparam int unsigned NI = 3;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int unsigned  lat;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int unsigned  lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a [NI];
    logic [1:0]   op_a    [NI];
    logic [W-1:0] a_a     [NI];
    logic [W-1:0] b_a     [NI];
    logic         busy_a  [NI];
    logic         done_a  [NI];
    logic [W-1:0] hi_a    [NI];
    logic [W-1:0] lo_a    [NI];
    logic         dz_a    [NI];

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_div #(.WIDTH(W), .STEPS(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_a[g]),
            .op       (op_a[g]),
            .dividend (a_a[g]),
            .divisor  (b_a[g]),
            .busy     (busy_a[g]),
            .done     (done_a[g]),
            .hi       (hi_a[g]),
            .lo       (lo_a[g]),
            .dz       (dz_a[g])
        );
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int unsigned steps);
        exp_t e;
        e.lat = W / steps + 1;
        e.dz  = 1'b0;
        if (b == '0) begin
            e.dz  = 1'b1;
            e.lo  = '1;
            e.hi  = a;
            e.lat = 1;
        end else if (!op[0]) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = '0;
        end else begin
            e.lo = W'($signed(a) / $signed(b));
            e.hi = W'($signed(a) % $signed(b));
        end
        return e;
    endfunction

    // Called at a negedge: present a request and record what it must produce
    task automatic issue(input int k, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e);
        start_a[k] = 1'b1;
        op_a[k]    = op;
        a_a[k]     = a;
        b_a[k]     = b;
        sb.push_back(e);
    endtask

    // Waits for done, counting edges after accept; optionally pokes a start while busy
    task automatic collect(input int k, input string tag, input int poke);
        exp_t        e;
        int unsigned lat = 0;
        @(negedge clk);
        start_a[k] = 1'b0;
        a_a[k]     = $urandom;
        b_a[k]     = $urandom;
        while (!done_a[k] && lat < 200) begin
            if (poke >= 0 && lat == poke) begin
                start_a[k] = 1'b1;
                op_a[k]    = 2'b10;
                a_a[k]     = 32'd9;
                b_a[k]     = 32'd3;
            end else begin
                start_a[k] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start_a[k] = 1'b0;
        if (!done_a[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: done not seen within %0d cycles", tag, lat);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: done with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        check($sformatf("%s lo", tag),   lo_a[k], e.lo);
        check($sformatf("%s hi", tag),   hi_a[k], e.hi);
        check($sformatf("%s dz", tag),   W'(dz_a[k]), W'(e.dz));
        check($sformatf("%s lat", tag),  W'(lat), W'(e.lat));
        check($sformatf("%s busy", tag), W'(busy_a[k]), '0);
    endtask

    initial begin
        vec_t vecs [12];
        exp_t e;
        vecs[0]  = '{2'b10, 32'd34,        32'hFFFF_FFFB, 32'h0000_0022, 32'h0000_0000, 1'b0, 33};
        vecs[1]  = '{2'b11, 32'd34,        32'hFFFF_FFFB, 32'h0000_0004, 32'hFFFF_FFFA, 1'b0, 33};
        vecs[2]  = '{2'b11, 32'hFFFF_FFDE, 32'd5,         32'hFFFF_FFFC, 32'hFFFF_FFFA, 1'b0, 33};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33};
        vecs[5]  = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{2'b10, 32'd10,        32'd3,         32'h0000_0001, 32'h0000_0003, 1'b0, 33};
        vecs[7]  = '{2'b11, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[9]  = '{2'b11, 32'd7,         32'd7,         32'h0000_0000, 32'h0000_0001, 1'b0, 33};
        vecs[10] = '{2'b10, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[11] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 33};

        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_a[k] = 1'b0;
            op_a[k]    = 2'b00;
            a_a[k]     = '0;
            b_a[k]     = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset%0d busy", k), W'(busy_a[k]), '0);
            check($sformatf("reset%0d done", k), W'(done_a[k]), '0);
            check($sformatf("reset%0d lo", k),   lo_a[k], '0);
            check($sformatf("reset%0d hi", k),   hi_a[k], '0);
            check($sformatf("reset%0d dz", k),   W'(dz_a[k]), '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Invalid op codes must not start anything
        start_a[0] = 1'b1; op_a[0] = 2'b01; a_a[0] = 32'd5; b_a[0] = 32'd1;
        @(negedge clk);
        check("badop01 busy", W'(busy_a[0]), '0);
        op_a[0] = 2'b00;
        @(negedge clk);
        start_a[0] = 1'b0;
        check("badop00 busy", W'(busy_a[0]), '0);
        repeat (3) @(negedge clk);
        check("badop done", W'(done_a[0]), '0);
        check("badop lo", lo_a[0], '0);

        // Directed table, issued back-to-back in each done cycle
        for (int i = 0; i < 12; i++) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dz = vecs[i].dz; e.lat = vecs[i].lat;
            issue(0, vecs[i].op, vecs[i].a, vecs[i].b, e);
            collect(0, $sformatf("vec%0d", i), -1);
        end
        repeat (5) @(negedge clk);
        check("hold lo", lo_a[0], 32'h0000_0003);
        check("hold hi", hi_a[0], 32'hFFFF_FFFF);
        check("hold dz", W'(dz_a[0]), '0);

        // Start while busy is ignored
        e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0; e.lat = 33;
        issue(0, 2'b10, 32'd100, 32'd7, e);
        collect(0, "busy_start", 5);

        // Reset mid-op discards the op
        start_a[0] = 1'b1; op_a[0] = 2'b10; a_a[0] = 32'd100; b_a[0] = 32'd7;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midop lo held", lo_a[0], 32'd14);
        repeat (5) @(negedge clk);
        check("midop busy", W'(busy_a[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", W'(busy_a[0]), '0);
        check("midrst lo", lo_a[0], '0);
        check("midrst hi", hi_a[0], '0);
        check("midrst done", W'(done_a[0]), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst done", W'(done_a[0]), '0);
        check("postrst busy", W'(busy_a[0]), '0);
        issue(0, 2'b10, 32'd100, 32'd7, e);
        collect(0, "fresh", -1);
        @(negedge clk);
        check("done pulse", W'(done_a[0]), '0);
        check("fresh hold lo", lo_a[0], 32'd14);

        // Random back-to-back ops on every STEPS variant
        for (int k = 0; k < NI; k++) begin
            int unsigned nops = (k == 0) ? 100 : 2000;
            for (int unsigned i = 0; i < nops; i++) begin
                logic [1:0]   op;
                logic [W-1:0] a, b;
                op = $urandom_range(0, 1) ? 2'b11 : 2'b10;
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 9))
                    0: b = '0;
                    1: b = '1;
                    2: begin a = 32'h8000_0000; if ($urandom_range(0, 1) == 1) b = '1; end
                    3: b = $urandom_range(1, 15);
                    4: a = $urandom_range(0, 100);
                    default: ;
                endcase
                issue(k, op, a, b, model(op, a, b, 1 << k));
                collect(k, $sformatf("rnd s%0d #%0d", 1 << k, i), -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
